// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE, RUN, HALT)
//   DEFAULT_WORD  : default PC / instruction width
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  localparam int unsigned DEFAULT_WORD = 8;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with load (redirect), increment and hold.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_en    : load load_addr (has priority over inc_en)
//   load_addr  : redirect target
//   inc_en     : advance PC by one, wrapping modulo 2^WORD
//   pc         : current PC register value
//   next_pc    : value the PC takes on the coming edge
module fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter int unsigned          WORD     = DEFAULT_WORD,
  parameter logic [WORD-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [WORD-1:0] load_addr,
  input  logic            inc_en,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] next_pc
);

  logic [WORD-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_addr;
    end else if (inc_en) begin
      pc_d = pc_q + WORD'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign next_pc = pc_d;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the combinational instruction memory from the PC and
// registers {instruction, PC} into one valid/ready output slot.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_addr / imem_data : instruction memory address out / data in (same cycle)
//   jump_en / jump_addr   : redirect request and target
//   halt                  : level, stops new fetches while high
//   out_valid / out_ready : output slot handshake toward decode
//   out_instr / out_pc    : slot payload
//   halted                : FSM is in HALT (registered)
//   fetch_cnt             : saturating count of accepted slots
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     WORD     = DEFAULT_WORD,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WORD-1:0]  imem_addr,
  input  logic [WORD-1:0]  imem_data,
  input  logic             jump_en,
  input  logic [WORD-1:0]  jump_addr,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_instr,
  output logic [WORD-1:0]  out_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_t    state_d, state_q;
  logic            halted_d, halted_q;
  logic            valid_d, valid_q;
  logic [WORD-1:0] instr_d, instr_q;
  logic [WORD-1:0] opc_d, opc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [WORD-1:0] pc;
  logic [WORD-1:0] unused_next_pc;
  logic            jump_take, slot_free, fire, handshake;

  // Redirects are ignored in IDLE; elsewhere they override fetch and stall.
  assign jump_take = jump_en && (state_q != IDLE);
  assign slot_free = !valid_q || out_ready;
  assign fire      = (state_q == RUN) && !halt && !jump_en && slot_free;
  assign handshake = valid_q && out_ready;

  fetch_pc #(
    .WORD     (WORD),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (jump_take),
    .load_addr (jump_addr),
    .inc_en    (fire),
    .pc        (pc),
    .next_pc   (unused_next_pc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt && !jump_en) state_d = HALT;
      HALT:    if (!halt || jump_en) state_d = RUN;
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == HALT);
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    if (jump_take) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d = 1'b1;
      instr_d = imem_data;
      opc_d   = pc;
    end else if (out_ready) begin
      // Slot consumed with nothing to refill it; payload keeps last value.
      valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    // A handshake coinciding with a jump still counts as delivered.
    if (handshake && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr = pc;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign halted    = halted_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle vectors plus
// hand-written sequences for async reset mid-stream and counter saturation.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en, halt, out_ready;
  logic [7:0]  jump_addr;

  logic [7:0]  imem_addr, imem_data, out_instr, out_pc;
  logic        out_valid, halted;
  logic [15:0] fetch_cnt;

  // Second instance with a 3-bit counter to reach saturation quickly.
  logic [7:0]  s_imem_addr, s_imem_data, s_out_instr, s_out_pc;
  logic        s_out_valid, s_halted;
  logic [2:0]  s_fetch_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    case (a)
      8'd0:    return 8'h80;
      8'd1:    return 8'h40;
      8'd2:    return 8'h20;
      8'd3:    return 8'h10;
      8'd4:    return 8'h08;
      8'd5:    return 8'h04;
      8'd6:    return 8'h02;
      8'd7:    return 8'h01;
      8'd8:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  assign imem_data   = mem_rd(imem_addr);
  assign s_imem_data = mem_rd(s_imem_addr);

  instr_fetch #(.WORD(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .halt      (halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  instr_fetch #(.WORD(8), .RESET_PC(8'h00), .CNT_W(3)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (s_imem_addr),
    .imem_data (s_imem_data),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .halt      (halt),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_instr (s_out_instr),
    .out_pc    (s_out_pc),
    .halted    (s_halted),
    .fetch_cnt (s_fetch_cnt)
  );

  typedef struct {
    logic        rdy;
    logic        jmp;
    logic [7:0]  jaddr;
    logic        hlt;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [7:0]  e_instr;
    logic [7:0]  e_addr;
    logic [15:0] e_cnt;
    logic        e_halted;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic j, input logic [7:0] ja, input logic h,
                              input logic v, input logic [7:0] p, input logic [7:0] ins,
                              input logic [7:0] a, input logic [15:0] c, input logic hd);
    vec_t x;
    x.rdy = r; x.jmp = j; x.jaddr = ja; x.hlt = h;
    x.e_valid = v; x.e_pc = p; x.e_instr = ins; x.e_addr = a; x.e_cnt = c; x.e_halted = hd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] p,
                           input logic [7:0] ins, input logic [7:0] a, input logic [15:0] c,
                           input logic hd);
    check({tag, " out_valid"}, 32'(out_valid), 32'(v));
    check({tag, " out_pc"},    32'(out_pc),    32'(p));
    check({tag, " out_instr"}, 32'(out_instr), 32'(ins));
    check({tag, " imem_addr"}, 32'(imem_addr), 32'(a));
    check({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'(c));
    check({tag, " halted"},    32'(halted),    32'(hd));
  endtask

  // Advance one cycle and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rdy jmp jaddr hlt | valid pc instr addr cnt halted
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0)); // IDLE -> RUN
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 8'h80, 8'h01, 0, 0)); // first fetch
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 8'h40, 8'h02, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h20, 8'h03, 2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h02, 8'h20, 8'h03, 2, 0)); // stall x3
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h02, 8'h20, 8'h03, 2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h02, 8'h20, 8'h03, 2, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h03, 8'h10, 8'h04, 3, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h04, 8'h08, 8'h05, 4, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h04, 8'h08, 8'h05, 4, 0)); // (4,08) stalled
    tbl.push_back(mk(0, 1, 8'h07, 0, 0, 8'h04, 8'h08, 8'h07, 4, 0)); // jump flushes slot
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h07, 8'h01, 8'h08, 4, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h08, 8'hFF, 8'h09, 5, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h09, 8'h00, 8'h0A, 6, 0));
    tbl.push_back(mk(1, 1, 8'hFE, 0, 0, 8'h09, 8'h00, 8'hFE, 7, 0)); // jump + handshake
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hFE, 8'h00, 8'hFF, 7, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 8'h00, 8, 0)); // PC wraps
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 8'h80, 8'h01, 9, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h01, 8'h40, 8'h02, 10, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h01, 8'h40, 8'h02, 10, 1)); // halt, slot pending
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h01, 8'h40, 8'h02, 11, 1)); // slot delivered
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h01, 8'h40, 8'h02, 11, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h01, 8'h40, 8'h02, 11, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h01, 8'h40, 8'h02, 11, 0)); // HALT -> RUN
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h20, 8'h03, 11, 0)); // resume at 2
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h02, 8'h20, 8'h03, 12, 1));
    tbl.push_back(mk(1, 1, 8'h05, 1, 0, 8'h02, 8'h20, 8'h05, 12, 0)); // jump in HALT
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h02, 8'h20, 8'h05, 12, 1)); // back to HALT
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h02, 8'h20, 8'h05, 12, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h05, 8'h04, 8'h06, 12, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h06, 8'h02, 8'h07, 13, 0));

    rst_n = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; halt = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 8'h00, 8'h00, 8'h00, 16'd0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      out_ready = tbl[i].rdy;
      jump_en   = tbl[i].jmp;
      jump_addr = tbl[i].jaddr;
      halt      = tbl[i].hlt;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr,
                tbl[i].e_addr, tbl[i].e_cnt, tbl[i].e_halted);
    end

    // Async reset mid-stream, away from any clock edge.
    jump_en = 1'b0; halt = 1'b0; out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 8'h00, 8'h00, 8'h00, 16'd0, 1'b0);
    check("async_rst s_cnt", 32'(s_fetch_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_all("restart idle", 1'b0, 8'h00, 8'h00, 8'h00, 16'd0, 1'b0);
    step();
    check_all("restart first", 1'b1, 8'h00, 8'h80, 8'h01, 16'd0, 1'b0);

    // Streaming: k-th accepted slot, small counter pins at 7.
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("stream%0d out_pc", k), 32'(out_pc), 32'(k));
      check($sformatf("stream%0d cnt", k), 32'(fetch_cnt), 32'(k));
      check($sformatf("stream%0d s_cnt", k), 32'(s_fetch_cnt), 32'((k > 7) ? 7 : k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that drives the address of the combinational instruction_mem and consumes its data.
- Holds the program counter (PC) and registers {instruction, PC} into a single output slot.
- The output slot uses a valid/ready handshake toward the decode stage.
- Supports jump/redirect, halt and back-pressure, and keeps a saturating fetch counter for debug.

Parameters:
- WORD, 8: width of PC, instruction memory address and instruction data.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  WORD  address to instruction_mem; combinational copy of the PC register.
- imem_data  in  WORD  instruction from instruction_mem; valid in the same cycle as imem_addr.
- jump_en  in  1  redirect request, single-cycle pulse or level.
- jump_addr  in  WORD  redirect target.
- halt  in  1  level; stops new fetches while high.
- out_valid  out  1  output slot holds a valid instruction.
- out_ready  in  1  decode accepts the slot this cycle.
- out_instr  out  WORD  fetched instruction.
- out_pc  out  WORD  address the instruction was fetched from.
- halted  out  1  FSM is in HALT.
- fetch_cnt  out  CNT_W  number of instructions handed off (out_valid && out_ready); saturates.

Behaviour:
- Reset (async assert, sync deassert):
  - pc = RESET_PC; out_valid = 0; out_instr = 0; out_pc = 0; fetch_cnt = 0; halted = 0.
  - FSM = IDLE.
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN unconditionally on the first clock after reset. No fetch happens in IDLE, so the first fetch is on the 2nd edge after reset release.
  - RUN → HALT when halt = 1 and jump_en = 0.
  - HALT → RUN when halt = 0, or when jump_en = 1.
  - halted = (state == HALT), registered.
- slot_free = !out_valid || out_ready.
- fire = (state == RUN) && !halt && !jump_en && slot_free.
  - On fire: out_instr <= imem_data; out_pc <= pc; out_valid <= 1; pc <= pc + 1.
  - PC increment wraps modulo 2^WORD: 0xFF → 0x00 for WORD = 8.
- Latency: an instruction at address A appears on out_instr one cycle after the cycle in which pc == A and fire is high.
  - Sustained throughput with out_ready = 1 is 1 instruction per cycle.
- Stall (out_valid = 1, out_ready = 0, no jump): pc, out_instr, out_pc and out_valid all hold, so the payload is stable until accepted.
- Slot accepted and no fire (halt, IDLE or HALT state): out_valid <= 0; out_instr and out_pc hold their last values.
- Jump, in any state except IDLE, takes priority over everything:
  - pc <= jump_addr; out_valid <= 0 (flushes the slot even if stalled); no fetch that cycle.
  - The next cycle fetches from jump_addr if the FSM is in RUN and halt = 0.
  - Jump in HALT with halt still high: pc is updated, FSM goes to RUN, but no fetch occurs while halt stays high. The next cycle re-evaluates RUN → HALT.
  - Jump in IDLE is ignored.
- Jump in the same cycle as a handshake: the handshake still counts for fetch_cnt (the instruction was accepted), then the slot is cleared.
- fetch_cnt increments when out_valid && out_ready, and saturates at all-ones.
- halt asserted while out_valid = 1: the slot is still delivered normally. No new fetch happens until halt drops.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), including out_valid = 0.

Decomposition:
- Package instr_fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, RUN, HALT};
  - localparam DEFAULT_WORD = 8.
- One natural sub-module: fetch_pc. It is the PC register with increment, load and hold, and exposes a combinational next_pc.
- The output slot, FSM and counter live in the top module.

Test Plan (instruction_mem instance holds 0:0x80, 1:0x40, 2:0x20, 3:0x10, 4:0x08, 5:0x04, 6:0x02, 7:0x01, 8:0xFF, others 0x00):
- Reset release, out_ready = 1 → out_valid rises 2 cycles after release; then (pc, instr) = (0,0x80), (1,0x40), … (8,0xFF), (9,0x00) on consecutive cycles.
- out_ready = 0 for 3 cycles while holding (2,0x20) → out_instr/out_pc stable, imem_addr stays 3; after ready, (3,0x10) follows next cycle; fetch_cnt increments exactly once per handshake.
- jump_en with jump_addr = 7 while (4,0x08) is stalled → slot dropped (out_valid = 0 next cycle), then (7,0x01), (8,0xFF); fetch_cnt not incremented for the dropped slot.
- Wrap: jump to 0xFE, ready = 1 → (0xFE,0x00), (0xFF,0x00), (0x00,0x80).
- halt = 1 for 4 cycles from RUN → halted = 1 next cycle, no new slots, pending slot still delivered; halt = 0 → resumes at next sequential PC.
- rst_n pulsed low mid-stream with out_valid = 1 → out_valid, pc and fetch_cnt clear immediately; restart from address 0; fetch_cnt = 0xFFFF holds at saturation (forced via long run or short-CNT_W build).
